// File: rtl/polaris_bus_pkg.sv
// Polaris D-bus shared types: transfer size codes, responder states, captured request, lane helpers.
// Pure declarations; no latency or backpressure of its own.
package polaris_bus_pkg;

    typedef enum logic [1:0] {
        DSIZ_BYTE  = 2'd0,
        DSIZ_HALF  = 2'd1,
        DSIZ_WORD  = 2'd2,
        DSIZ_DWORD = 2'd3
    } dsiz_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } rsp_state_t;

    typedef struct packed {
        logic        we;
        dsiz_t       siz;
        logic        sgn;
        logic        mis;
        logic [2:0]  off;
        logic [63:0] dat;
    } dreq_t;

    function automatic logic [7:0] lane_mask(input dsiz_t siz, input logic [2:0] off);
        logic [7:0] m;
        case (siz)
            DSIZ_BYTE: m = 8'h01;
            DSIZ_HALF: m = 8'h03;
            DSIZ_WORD: m = 8'h0F;
            default:   m = 8'hFF;
        endcase
        return m << off;
    endfunction

    function automatic logic misaligned(input dsiz_t siz, input logic [2:0] off);
        logic [2:0] amask;
        case (siz)
            DSIZ_BYTE: amask = 3'b000;
            DSIZ_HALF: amask = 3'b001;
            DSIZ_WORD: amask = 3'b011;
            default:   amask = 3'b111;
        endcase
        return (off & amask) != 3'b000;
    endfunction

endpackage

// File: rtl/dmem_lane_ram.sv
// Single-port 64-bit RAM with per-byte write enables; read data registered (1 cycle).
// No backpressure: one access per cycle, write and read share the address.
module dmem_lane_ram #(
    parameter int DEPTH_LOG2 = 9
) (
    input  logic                  clk,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [7:0]            wr_be,
    input  logic [63:0]           wr_dat,
    output logic [63:0]           rd_dat
);

    logic [63:0] mem [0:(1 << DEPTH_LOG2) - 1];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 8; b++) begin
            if (wr_be[b]) begin
                mem[addr][b*8 +: 8] <= wr_dat[b*8 +: 8];
            end
        end
        rd_dat <= mem[addr];
    end

endmodule

// File: rtl/polaris_dmem_responder.sv
// Polaris D-bus data RAM slave: sized little-endian access with sign/zero extension.
// Latency WAIT_STATES+1 cycles to dack_o; single outstanding, new requests ignored until back in IDLE.
module polaris_dmem_responder
    import polaris_bus_pkg::*;
#(
    parameter int DEPTH_LOG2  = 9,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        dcyc_i,
    input  logic        dstb_i,
    input  logic        dwe_i,
    input  logic [63:0] dadr_i,
    input  logic [63:0] ddat_i,
    input  logic [1:0]  dsiz_i,
    input  logic        dsigned_i,
    output logic        dack_o,
    output logic [63:0] ddat_o,
    output logic        misalign_o
);

    localparam logic [3:0] WS_LAST = 4'(WAIT_STATES - 1);

    rsp_state_t            state;
    rsp_state_t            state_nxt;
    logic                  capture;
    logic [3:0]            wait_cnt;
    dreq_t                 req;
    logic [DEPTH_LOG2-1:0] cap_idx;
    logic [DEPTH_LOG2-1:0] ram_addr;
    logic [7:0]            ram_be;
    logic [63:0]           ram_wdat;
    logic [63:0]           ram_rdat;
    logic [63:0]           shifted;
    logic [63:0]           rd_ext;
    logic                  unused_adr;

    assign unused_adr = ^dadr_i[63:DEPTH_LOG2+3];

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (dcyc_i && dstb_i) begin
                    capture   = 1'b1;
                    state_nxt = (WAIT_STATES == 0) ? ST_ACK : ST_WAIT;
                end
            end
            ST_WAIT: begin
                // a dropped cycle abandons the transfer even on its last wait cycle
                if (!dcyc_i) begin
                    state_nxt = ST_IDLE;
                end else if (wait_cnt == WS_LAST) begin
                    state_nxt = ST_ACK;
                end
            end
            ST_ACK:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state    <= ST_IDLE;
            wait_cnt <= 4'd0;
            req      <= '0;
            cap_idx  <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_WAIT && state_nxt == ST_WAIT) begin
                wait_cnt <= wait_cnt + 4'd1;
            end else begin
                wait_cnt <= 4'd0;
            end
            if (capture) begin
                req.we  <= dwe_i;
                req.siz <= dsiz_t'(dsiz_i);
                req.sgn <= dsigned_i;
                req.mis <= misaligned(dsiz_t'(dsiz_i), dadr_i[2:0]);
                req.off <= dadr_i[2:0];
                req.dat <= ddat_i;
                cap_idx <= dadr_i[DEPTH_LOG2+2:3];
            end
        end
    end

    // In IDLE the RAM follows the live bus so a zero-wait read has data by ACK.
    assign ram_addr = (state == ST_IDLE) ? dadr_i[DEPTH_LOG2+2:3] : cap_idx;
    assign ram_be   = (state == ST_ACK && req.we && !req.mis) ? lane_mask(req.siz, req.off) : 8'h00;
    assign ram_wdat = req.dat << {req.off, 3'b000};

    dmem_lane_ram #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk    (clk_i),
        .addr   (ram_addr),
        .wr_be  (ram_be),
        .wr_dat (ram_wdat),
        .rd_dat (ram_rdat)
    );

    always_comb begin
        shifted = ram_rdat >> {req.off, 3'b000};
        case (req.siz)
            DSIZ_BYTE: rd_ext = req.sgn ? {{56{shifted[7]}}, shifted[7:0]}   : {56'd0, shifted[7:0]};
            DSIZ_HALF: rd_ext = req.sgn ? {{48{shifted[15]}}, shifted[15:0]} : {48'd0, shifted[15:0]};
            DSIZ_WORD: rd_ext = req.sgn ? {{32{shifted[31]}}, shifted[31:0]} : {32'd0, shifted[31:0]};
            default:   rd_ext = shifted;
        endcase
    end

    assign dack_o     = (state == ST_ACK);
    assign misalign_o = dack_o & req.mis;
    assign ddat_o     = (dack_o && !req.we && !req.mis) ? rd_ext : 64'd0;

endmodule

// File: tb/tb_polaris_dmem_responder.sv
// Scoreboard bench: dut1 runs with one wait state, dut0 with none; a negedge monitor checks every ack.
module tb_polaris_dmem_responder;

    typedef struct {
        logic [63:0] dat;
        logic        mis;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  cyc, stb, we, sgn, ack, mis;
    logic [63:0] adr  [2];
    logic [63:0] wdat [2];
    logic [63:0] rdat [2];
    logic [1:0]  siz  [2];

    exp_t sb0[$];
    exp_t sb1[$];
    int   cyc_cnt  = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    localparam logic [63:0] D0 = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] D1 = 64'h0123_4567_80AB_CDEF;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    polaris_dmem_responder #(.DEPTH_LOG2(9), .WAIT_STATES(0)) dut0 (
        .clk_i(clk), .reset_i(rst), .dcyc_i(cyc[0]), .dstb_i(stb[0]), .dwe_i(we[0]),
        .dadr_i(adr[0]), .ddat_i(wdat[0]), .dsiz_i(siz[0]), .dsigned_i(sgn[0]),
        .dack_o(ack[0]), .ddat_o(rdat[0]), .misalign_o(mis[0])
    );

    polaris_dmem_responder #(.DEPTH_LOG2(9), .WAIT_STATES(1)) dut1 (
        .clk_i(clk), .reset_i(rst), .dcyc_i(cyc[1]), .dstb_i(stb[1]), .dwe_i(we[1]),
        .dadr_i(adr[1]), .ddat_i(wdat[1]), .dsiz_i(siz[1]), .dsigned_i(sgn[1]),
        .dack_o(ack[1]), .ddat_o(rdat[1]), .misalign_o(mis[1])
    );

    task automatic compare(input int d, input exp_t e);
        n_checks++;
        if (rdat[d] !== e.dat) begin
            n_fail++;
            $display("FAIL ack_data dut%0d: ddat_o=%h required %h", d, rdat[d], e.dat);
        end
        n_checks++;
        if (mis[d] !== e.mis) begin
            n_fail++;
            $display("FAIL ack_misalign dut%0d: misalign_o=%b required %b", d, mis[d], e.mis);
        end
        n_checks++;
        if (cyc_cnt != e.due) begin
            n_fail++;
            $display("FAIL ack_latency dut%0d: dack_o in cycle %0d required cycle %0d", d, cyc_cnt, e.due);
        end
    endtask

    always @(negedge clk) begin
        if (ack[0]) begin
            if (sb0.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_ack dut0: dack_o=1 with nothing outstanding at cycle %0d", cyc_cnt);
            end else begin
                compare(0, sb0.pop_front());
            end
        end
        if (ack[1]) begin
            if (sb1.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_ack dut1: dack_o=1 with nothing outstanding at cycle %0d", cyc_cnt);
            end else begin
                compare(1, sb1.pop_front());
            end
        end
        for (int d = 0; d < 2; d++) begin
            if (!ack[d]) begin
                n_checks++;
                if (mis[d] !== 1'b0 || rdat[d] !== 64'd0) begin
                    n_fail++;
                    $display("FAIL idle_outputs dut%0d: misalign_o=%b ddat_o=%h required 0 and 0", d, mis[d], rdat[d]);
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 so calls chain back-to-back.
    task automatic xfer(input int d, input logic w, input logic [63:0] a, input logic [63:0] wd,
                        input logic [1:0] sz, input logic sg, input logic [63:0] ed, input logic em);
        exp_t e;
        bit   got;
        cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; wdat[d] = wd; siz[d] = sz; sgn[d] = sg;
        e.dat = ed;
        e.mis = em;
        e.due = cyc_cnt + ((d == 0) ? 1 : 2);
        if (d == 0) sb0.push_back(e); else sb1.push_back(e);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (ack[d]) got = 1'b1;
        end
        if (!got) begin
            n_checks++; n_fail++;
            $display("FAIL ack_timeout dut%0d adr=%h: dack_o=0 for 20 cycles, required 1", d, a);
        end
        @(posedge clk); #1;
        cyc[d] = 1'b0; stb[d] = 1'b0;
    endtask

    task automatic check_no_ack(input string name, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            n_checks++;
            if (ack[1] !== 1'b0) begin
                n_fail++;
                $display("FAIL %s: dack_o=%b required 0", name, ack[1]);
            end
        end
    endtask

    task automatic abort_write(input logic [63:0] a, input logic [63:0] wd);
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = a; wdat[1] = wd; siz[1] = 2'd3; sgn[1] = 1'b0;
        @(posedge clk); #1;
        cyc[1] = 1'b0; stb[1] = 1'b0;
        check_no_ack("abort_no_ack", 3);
        @(posedge clk); #1;
    endtask

    task automatic reset_in_wait(input logic [63:0] a, input logic [63:0] wd);
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = a; wdat[1] = wd; siz[1] = 2'd3; sgn[1] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        stb[1] = 1'b0;
        #1;
        n_checks++;
        if (ack[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_wait_ack: dack_o=%b required 0", ack[1]);
        end
        #2 rst = 1'b0;
        check_no_ack("reset_wait_no_ack", 3);
        cyc[1] = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic reset_in_ack(input logic [63:0] a);
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b0; adr[1] = a; wdat[1] = 64'd0; siz[1] = 2'd3; sgn[1] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_checks++;
        if (ack[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ack_reached: dack_o=%b required 1", ack[1]);
        end
        rst = 1'b1;
        stb[1] = 1'b0;
        #1;
        n_checks++;
        if (ack[1] !== 1'b0 || rdat[1] !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_ack_drop: dack_o=%b ddat_o=%h required 0 and 0", ack[1], rdat[1]);
        end
        #2 rst = 1'b0;
        cyc[1] = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1;
        cyc = '0; stb = '0; we = '0; sgn = '0;
        for (int d = 0; d < 2; d++) begin
            adr[d] = 64'd0; wdat[d] = 64'd0; siz[d] = 2'd0;
        end
        #8;
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (ack[d] !== 1'b0 || mis[d] !== 1'b0 || rdat[d] !== 64'd0) begin
                n_fail++;
                $display("FAIL reset_state dut%0d: dack=%b misalign=%b ddat=%h required 0/0/0", d, ack[d], mis[d], rdat[d]);
            end
        end
        #4 rst = 1'b0;
        @(posedge clk); #1;

        // one wait state: dword, byte, half, word, misaligned, aliasing, top index
        xfer(1, 1, 64'h10, D0, 2'd3, 0, 64'd0, 0);
        xfer(1, 0, 64'h10, 64'd0, 2'd3, 0, D0, 0);
        xfer(1, 1, 64'h13, 64'hFFFF_FFFF_FFFF_FF80, 2'd0, 0, 64'd0, 0);
        xfer(1, 0, 64'h13, 64'd0, 2'd0, 1, 64'hFFFF_FFFF_FFFF_FF80, 0);
        xfer(1, 0, 64'h13, 64'd0, 2'd0, 0, 64'h80, 0);
        xfer(1, 0, 64'h10, 64'd0, 2'd3, 0, D1, 0);
        xfer(1, 0, 64'h10, 64'd0, 2'd1, 0, 64'hCDEF, 0);
        xfer(1, 0, 64'h12, 64'd0, 2'd1, 1, 64'hFFFF_FFFF_FFFF_80AB, 0);
        xfer(1, 0, 64'h11, 64'd0, 2'd1, 0, 64'd0, 1);
        xfer(1, 1, 64'h11, 64'hBEEF, 2'd1, 0, 64'd0, 1);
        xfer(1, 0, 64'h10, 64'd0, 2'd3, 0, D1, 0);
        xfer(1, 0, 64'h10, 64'd0, 2'd2, 1, 64'hFFFF_FFFF_80AB_CDEF, 0);
        xfer(1, 0, 64'h14, 64'd0, 2'd2, 1, 64'h0000_0000_0123_4567, 0);
        xfer(1, 0, 64'h12, 64'd0, 2'd2, 0, 64'd0, 1);
        xfer(1, 0, 64'hF000_0000_0000_1010, 64'd0, 2'd3, 1, D1, 0);
        xfer(1, 1, 64'hFF8, 64'hA5A5_5A5A_0F0F_F0F0, 2'd3, 0, 64'd0, 0);
        xfer(1, 0, 64'hFF8, 64'd0, 2'd3, 0, 64'hA5A5_5A5A_0F0F_F0F0, 0);

        // zero wait states
        xfer(0, 1, 64'h14, 64'h8000_0001, 2'd2, 0, 64'd0, 0);
        xfer(0, 1, 64'h10, 64'h1234_5678, 2'd2, 0, 64'd0, 0);
        xfer(0, 0, 64'h14, 64'd0, 2'd2, 1, 64'hFFFF_FFFF_8000_0001, 0);
        xfer(0, 0, 64'h14, 64'd0, 2'd2, 0, 64'h0000_0000_8000_0001, 0);
        xfer(0, 0, 64'h10, 64'd0, 2'd3, 0, 64'h8000_0001_1234_5678, 0);
        xfer(0, 0, 64'h14, 64'd0, 2'd3, 0, 64'd0, 1);
        xfer(0, 0, 64'h17, 64'd0, 2'd0, 1, 64'hFFFF_FFFF_FFFF_FF80, 0);
        xfer(0, 0, 64'h14, 64'd0, 2'd0, 0, 64'h01, 0);

        // abort and reset mid-transfer on the wait-state instance
        abort_write(64'h10, 64'h1111_1111_1111_1111);
        xfer(1, 0, 64'h10, 64'd0, 2'd3, 0, D1, 0);
        reset_in_wait(64'h10, 64'h2222_2222_2222_2222);
        xfer(1, 0, 64'h10, 64'd0, 2'd3, 0, D1, 0);
        reset_in_ack(64'h10);
        xfer(1, 0, 64'h10, 64'd0, 2'd3, 0, D1, 0);

        repeat (3) @(posedge clk);
        n_checks++;
        if (sb0.size() != 0) begin
            n_fail++;
            $display("FAIL drain dut0: %0d responses outstanding, required 0", sb0.size());
        end
        n_checks++;
        if (sb1.size() != 0) begin
            n_fail++;
            $display("FAIL drain dut1: %0d responses outstanding, required 0", sb1.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation did not complete within 200000 time units");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
